logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered bitwise logic unit; next generation of the 8-bit gate-level OR block.
//  Performs AND/OR/XOR/NOR/ANDN/ORN/PASS on WIDTH-bit operands selected by a 3-bit opcode, with a valid/ready handshake.
//  Results are buffered in a small output FIFO so the ALU issue stage is not stalled by a slow writeback consumer.
//  Sits between the decode/issue stage and the EX/WB mux of the MIPS32 datapath.
// PARAMETERS
//  WIDTH     32  operand/result width in bits (>=8)
//  TAG_W     5   width of the sideband tag (destination register index) carried with each op
//  OUT_DEPTH 2   output FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          operation request valid
//  in_ready   out  1          unit can accept a request this cycle
//  in_op      in   3          opcode (see BEHAVIOUR)
//  in_x       in   WIDTH      operand x
//  in_y       in   WIDTH      operand y
//  in_tag     in   TAG_W      sideband tag, returned unchanged
//  out_valid  out  1          result at FIFO head is valid
//  out_ready  in   1          consumer takes the head result this cycle
//  out_res    out  WIDTH      result
//  out_tag    out  TAG_W      tag of the result
//  out_zero   out  1          out_res == 0
//  out_err    out  1          opcode was illegal in this build
// BEHAVIOUR
//  - Reset (async assert, sync deassert): FIFO empty, count=0, out_valid=0, out_res=0, out_tag=0, out_zero=0, out_err=0, in_ready=1.
//  - Accept when in_valid & in_ready; result computed combinationally and written into FIFO on that edge.
//  - Latency: request accepted at edge N -> out_valid=1 visible after edge N (1 cycle) if FIFO was empty.
//  - Pop when out_valid & out_ready; head advances on that edge.
//  - in_ready = (count < OUT_DEPTH); depends on registered count only, never on out_ready (no comb in->out path).
//    Hence at full, a same-cycle pop does not allow a push; push resumes next cycle.
//  - Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
//  - Pointers wrap modulo OUT_DEPTH; count is $clog2(OUT_DEPTH)+1 bits.
//  - out_valid = (count != 0); out_* show head entry; when empty, out_res/out_tag/out_zero/out_err hold 0.
//  - Opcodes: 000 AND x&y; 001 OR x|y; 010 XOR x^y; 011 NOR ~(x|y); 100 ANDN x&~y; 101 ORN x|~y; 110 PASS x;
//    111 POPCNT (see CONFIGURATION). out_zero stored per entry from the computed result.
//  - Inputs are ignored when in_valid=0 or in_ready=0; a held request must stay stable until accepted (caller rule, asserted in sim).
//  - rst mid-operation flushes all buffered results; no partial output is produced.
// CONFIGURATION
//  - Macro LOGIC_UNIT_POPCNT_EN.
//  - Defined: op 111 = population count of x, zero-extended to WIDTH; out_err=0.
//  - Undefined: op 111 is illegal; entry stored with out_res=0, out_zero=1, out_err=1; handshake unchanged.
// STRUCTURE
//  - Package logic_unit_pkg: localparam opcode constants OP_AND..OP_POPCNT (3-bit), function for popcount.
//  - Sub-module logic_unit_fifo (params DW, DEPTH): sync FIFO with count, push/pop, in_ready/out_valid;
//    entry = {err, zero, tag, res}. Top holds opcode decode and result mux only.
// TESTING
//  - Reset: assert rst mid-stream with 2 entries buffered -> out_valid=0, in_ready=1 immediately; no stale result after release.
//  - Ops, WIDTH=32: x=0xF0F0_1234, y=0x0FF0_00FF, op=001 -> out_res=0xFFF0_12FF, out_zero=0; op=000 -> 0x00F0_0034;
//    op=010 -> 0xFF00_12CB; op=011 -> 0x000F_ED00; tags 3,4,5,6 returned in order.
//  - Backpressure: out_ready=0, issue 3 ops -> 2 accepted, in_ready=0 on 3rd; raise out_ready -> 3rd accepted one cycle after first pop.
//  - Streaming: out_ready=1, in_valid=1 for 16 cycles -> 16 results in order, throughput 1/cycle, 1-cycle latency.
//  - Zero flag: op=000 x=0xAAAA_AAAA y=0x5555_5555 -> out_res=0, out_zero=1.
//  - Op 111, x=0x8000_0003: with LOGIC_UNIT_POPCNT_EN -> out_res=3, out_err=0; without -> out_res=0, out_zero=1, out_err=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared definitions for the registered bitwise logic unit.
//   OP_*      3-bit opcode encodings
//   popcount  population count of a zero-extended operand (up to POP_MAX_W bits)
package logic_unit_pkg;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_NOR    = 3'b011;
  localparam logic [2:0] OP_ANDN   = 3'b100;
  localparam logic [2:0] OP_ORN    = 3'b101;
  localparam logic [2:0] OP_PASS   = 3'b110;
  localparam logic [2:0] OP_POPCNT = 3'b111;

  // Widest operand popcount accepts; callers zero-extend into this width.
  localparam int unsigned POP_MAX_W = 256;

  function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/logic_unit_fifo.sv
// logic_unit_fifo: synchronous result FIFO with occupancy count.
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   in_valid   push request; accepted when in_ready
//   in_ready   count < DEPTH (registered state only)
//   din        entry to store
//   out_valid  FIFO not empty
//   out_ready  consumer pops the head this cycle
//   dout       head entry, all zeros when empty
module logic_unit_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign dout      = out_valid ? mem[rd_ptr] : '0;

  // Storage is not reset: nothing reads it while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshake
// and an output result FIFO.
// Build option: define LOGIC_UNIT_POPCNT_EN to make opcode 111 a popcount of x
// (WIDTH must not exceed POP_MAX_W); otherwise 111 stores res=0, zero=1, err=1.
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake
//   in_op, in_x, in_y    opcode and operands
//   in_tag               sideband tag returned with the result
//   out_valid/out_ready  result handshake
//   out_res, out_tag     head result and its tag (0 when empty)
//   out_zero, out_err    result-is-zero and illegal-opcode flags (0 when empty)
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_err
);

  localparam int unsigned DW = WIDTH + TAG_W + 2;

  logic [WIDTH-1:0] res;
  logic             err;
  logic             zero;
  logic [DW-1:0]    head;

`ifdef LOGIC_UNIT_POPCNT_EN
  logic [POP_MAX_W-1:0] x_ext;
  logic [31:0]          pc;

  always_comb begin
    x_ext = '0;
    x_ext[WIDTH-1:0] = in_x;
  end

  assign pc = popcount(x_ext);
`endif

  always_comb begin
    res = '0;
    err = 1'b0;
    case (in_op)
      OP_AND:  res = in_x & in_y;
      OP_OR:   res = in_x | in_y;
      OP_XOR:  res = in_x ^ in_y;
      OP_NOR:  res = ~(in_x | in_y);
      OP_ANDN: res = in_x & ~in_y;
      OP_ORN:  res = in_x | ~in_y;
      OP_PASS: res = in_x;
`ifdef LOGIC_UNIT_POPCNT_EN
      OP_POPCNT: res = WIDTH'(pc);
`else
      OP_POPCNT: begin
        res = '0;
        err = 1'b1;
      end
`endif
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);

  logic_unit_fifo #(
    .DW    (DW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       ({err, zero, in_tag, res}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (head)
  );

  assign {out_err, out_zero, out_tag, out_res} = head;

  // Caller rule: a stalled request must be held unchanged until accepted.
  a_hold_stable: assert property (
    @(posedge clk) disable iff (rst)
      (in_valid && !in_ready) |=> (in_valid && $stable({in_op, in_x, in_y, in_tag}))
  );

endmodule
